data_mem_bridge: RTL and testbench
==================================

# data_mem_bridge

Data-memory access unit between the pipelined core's MEM-stage memory port and a word-wide valid/ready memory bus. Converts each load/store (address, write data, RISC-V funct3 format) into one aligned word transaction with byte strobes. Returns sign- or zero-extended load data and holds the pipeline with `stall` until the access completes. Rejects misaligned or undefined accesses without issuing a bus transaction, and bounds the wait for a read response with a timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles in WAIT_RESP before a read is abandoned. 0 disables the timeout.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset: 0 at a rising edge of `clock` resets the block.
- `core_address`  in  32  byte address of the access.
- `core_write_data`  in  32  store data; the low byte/half/word is used.
- `core_read_enable`  in  1  load request.
- `core_write_enable`  in  1  store request. Never asserted together with `core_read_enable`.
- `core_format`  in  3  funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `core_read_data`  out  32  extended load result, valid in the DONE cycle.
- `stall`  out  1  hold the pipeline (combinational).
- `access_fault`  out  1  one-cycle pulse in the DONE cycle of a rejected or timed-out access.
- `bus_valid`  out  1  request valid.
- `bus_ready`  in  1  request accepted when `bus_valid && bus_ready`.
- `bus_address`  out  32  word address, i.e. `{core_address[31:2], 2'b00}`.
- `bus_write`  out  1  1 = write, 0 = read.
- `bus_write_data`  out  32  store data replicated into the byte lanes.
- `bus_byte_enable`  out  4  write strobes. Zero for reads.
- `bus_response_valid`  in  1  read data valid.
- `bus_read_data`  in  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- **IDLE**
  - A request (`core_read_enable || core_write_enable`) gives `stall=1` in the same cycle.
  - At the next edge the block latches address, data, format and direction.
  - A legal request moves to REQ. An illegal one moves to DONE with fault.
- **Illegal accesses**
  - LW/SW with `address[1:0]!=0`.
  - LH/LHU/SH with `address[0]!=0`.
  - Loads with funct3 011, 110 or 111.
  - Stores with funct3 other than 000, 001, 010.
- **REQ**
  - `bus_valid=1`; all bus outputs are driven from the latched values and stay stable until the handshake.
  - On handshake: a write moves to DONE, a read moves to WAIT_RESP.
- **WAIT_RESP**
  - On `bus_response_valid`, capture the extended data and move to DONE.
  - The cycle counter increments each cycle. When it reaches `TIMEOUT_CYCLES` (nonzero) with no response, move to DONE with fault and data 0.
- **DONE**
  - `stall=0`, so the core advances at this edge.
  - `core_read_data` holds the captured value.
  - `access_fault` pulses if flagged.
  - Always returns to IDLE; the still-present core request is not re-issued.
- **Byte lanes (stores)**
  - SB: data `{4{wd[7:0]}}`, strobe `4'b0001 << addr[1:0]`.
  - SH: data `{2{wd[15:0]}}`, strobe `4'b0011 << addr[1:0]`.
  - SW: data `wd`, strobe `4'b1111`.
- **Load extraction**
  - Byte = `rdata >> (8*addr[1:0])`, halfword = `rdata >> (8*addr[1:0])`.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
- `bus_response_valid` in IDLE, REQ or DONE is ignored, including stale responses after a reset or timeout.

## Timing
- Reset values of outputs:
  - State IDLE, counter 0.
  - `bus_valid=0`, `bus_write=0`, `bus_byte_enable=0`, `bus_address=0`, `bus_write_data=0`.
  - `core_read_data=0`, `access_fault=0`.
  - `stall` follows its combinational rule (0 unless a request is present).
- Reset mid-transaction aborts immediately: `bus_valid` drops the next cycle and no DONE occurs.
- `stall` is 1 in IDLE-with-request, REQ and WAIT_RESP, and 0 in DONE and idle-without-request.
- Minimum store latency is 2 stall cycles (IDLE, REQ with ready), with DONE at cycle 2.
- Minimum load latency is 3 stall cycles (IDLE, REQ, WAIT with response), with DONE at cycle 3.
- Each extra cycle of `bus_ready=0` or missing response adds one stall cycle.
- Rejected access: 1 stall cycle, then DONE with fault at cycle 1.
- A timeout DONE occurs exactly `TIMEOUT_CYCLES` cycles after entry to WAIT_RESP.
- Back-to-back accesses: a new request is seen in the IDLE cycle right after DONE, so there are no dead cycles beyond that.

## Test plan
- **LW**
  - Stimulus: addr 0x100, `bus_ready=1`, response `0xDEADBEEF` one cycle after handshake.
  - Response: `stall` = 1,1,1,0; `bus_address=0x100`; `core_read_data=0xDEADBEEF` in DONE.
- **LB / LBU**
  - Stimulus: addr 0x203, read word `0x80FF1234`.
  - Response: LB gives `0xFFFFFF80`, LBU gives `0x00000080`. LH at 0x202 gives `0xFFFF80FF`.
- **SB**
  - Stimulus: addr 0x301, data `0x000000AB`, `bus_ready` low for 2 cycles.
  - Response: `bus_write_data=0xABABABAB`, `bus_byte_enable=4'b0010`, request held stable for 3 cycles, 4 stall cycles total.
- **Misaligned**
  - Stimulus: SW at 0x402, LH at 0x401.
  - Response: `bus_valid` never asserts; `access_fault` pulses in cycle 1; `core_read_data=0`.
- **Timeout**
  - Stimulus: `TIMEOUT_CYCLES=4`, read accepted, no response. A late response follows in IDLE.
  - Response: DONE with fault exactly 4 cycles after WAIT entry; the late response is ignored.
- **Reset**
  - Stimulus: `reset=0` during WAIT_RESP.
  - Response: next cycle state IDLE, `bus_valid=0`, `stall=0`. A subsequent LW completes normally.

Source files
------------

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: MEM-stage load/store unit bridging the core's memory
// port to a word-wide valid/ready bus with byte strobes.
//
// Ports:
//   clock, reset          clock; synchronous active-low reset
//   core_address          byte address of the access
//   core_write_data       store data (low byte/half/word used)
//   core_read_enable      load request
//   core_write_enable     store request
//   core_format           RISC-V funct3 (size / signedness)
//   core_read_data        extended load result, valid in DONE
//   stall                 hold the pipeline (combinational)
//   access_fault          DONE-cycle pulse for rejected/timed-out access
//   bus_valid/bus_ready   request handshake
//   bus_address           word-aligned address
//   bus_write             1 = write, 0 = read
//   bus_write_data        store data replicated into byte lanes
//   bus_byte_enable       write strobes, zero for reads
//   bus_response_valid    read data valid
//   bus_read_data         read word
module data_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] core_address,
    input  logic [31:0] core_write_data,
    input  logic        core_read_enable,
    input  logic        core_write_enable,
    input  logic [2:0]  core_format,
    output logic [31:0] core_read_data,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_address,
    output logic        bus_write,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    input  logic        bus_response_valid,
    input  logic [31:0] bus_read_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam bit          TMO_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 1;

    logic [1:0]  state;
    logic [31:0] wait_cnt;
    logic [1:0]  off_q;
    logic [2:0]  fmt_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        request;
    logic        fmt_b;
    logic        fmt_h;
    logic        fmt_w;
    logic        legal;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [31:0] shifted;
    logic        q_b;
    logic        q_h;
    logic        sx;
    logic [31:0] load_ext;

    assign request = core_read_enable | core_write_enable;
    assign fmt_b   = (core_format[1:0] == 2'b00);
    assign fmt_h   = (core_format[1:0] == 2'b01);
    assign fmt_w   = (core_format[1:0] == 2'b10);

    // Bit 2 of funct3 is the unsigned flag: meaningless for LW and
    // for every store, so it makes those encodings illegal.
    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            fmt_b: legal = !(core_write_enable && core_format[2]);
            fmt_h: legal = !core_address[0]
                           && !(core_write_enable && core_format[2]);
            fmt_w: legal = (core_address[1:0] == 2'b00)
                           && !core_format[2];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        st_data = core_write_data;
        st_be   = 4'b1111;
        unique case (1'b1)
            fmt_b: begin
                st_data = {4{core_write_data[7:0]}};
                st_be   = 4'b0001 << core_address[1:0];
            end
            fmt_h: begin
                st_data = {2{core_write_data[15:0]}};
                st_be   = 4'b0011 << core_address[1:0];
            end
            default: begin
                st_data = core_write_data;
                st_be   = 4'b1111;
            end
        endcase
    end

    assign shifted = bus_read_data >> {off_q, 3'b000};
    assign q_b     = (fmt_q[1:0] == 2'b00);
    assign q_h     = (fmt_q[1:0] == 2'b01);
    assign sx      = !fmt_q[2];

    always_comb begin
        load_ext = shifted;
        unique case (1'b1)
            q_b: load_ext = {{24{sx & shifted[7]}}, shifted[7:0]};
            q_h: load_ext = {{16{sx & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        unique case (state)
            S_IDLE: stall = request;
            S_REQ:  stall = 1'b1;
            S_WAIT: stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign bus_valid      = (state == S_REQ);
    assign core_read_data = rdata_q;
    assign access_fault   = fault_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            off_q           <= '0;
            fmt_q           <= '0;
            rdata_q         <= '0;
            fault_q         <= 1'b0;
            bus_address     <= '0;
            bus_write       <= 1'b0;
            bus_write_data  <= '0;
            bus_byte_enable <= '0;
        end else begin
            fault_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (request) begin
                        off_q    <= core_address[1:0];
                        fmt_q    <= core_format;
                        wait_cnt <= '0;
                        rdata_q  <= '0;
                        if (legal) begin
                            bus_address    <= {core_address[31:2],
                                               2'b00};
                            bus_write      <= core_write_enable;
                            bus_write_data <= st_data;
                            bus_byte_enable <= core_write_enable
                                               ? st_be : 4'b0000;
                            state          <= S_REQ;
                        end else begin
                            fault_q <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ready)
                        state <= bus_write ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (bus_response_valid) begin
                        rdata_q <= load_ext;
                        state   <= S_DONE;
                    end else if (TMO_ON && wait_cnt == TMO_LAST) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed bench with a latency/lane model and a
// single per-cycle compare process.
module tb_data_mem_bridge;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] core_address;
    logic [31:0] core_write_data;
    logic        core_read_enable;
    logic        core_write_enable;
    logic [2:0]  core_format;
    logic [31:0] core_read_data;
    logic        stall;
    logic        access_fault;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_address;
    logic        bus_write;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_response_valid;
    logic [31:0] bus_read_data;

    data_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clock              (clock),
        .reset              (reset),
        .core_address       (core_address),
        .core_write_data    (core_write_data),
        .core_read_enable   (core_read_enable),
        .core_write_enable  (core_write_enable),
        .core_format        (core_format),
        .core_read_data     (core_read_data),
        .stall              (stall),
        .access_fault       (access_fault),
        .bus_valid          (bus_valid),
        .bus_ready          (bus_ready),
        .bus_address        (bus_address),
        .bus_write          (bus_write),
        .bus_write_data     (bus_write_data),
        .bus_byte_enable    (bus_byte_enable),
        .bus_response_valid (bus_response_valid),
        .bus_read_data      (bus_read_data)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    bit          chk = 1'b0;
    bit          e_rst = 1'b0;
    logic        e_stall, e_valid, e_fault, e_write;
    bit          e_rd_chk = 1'b0;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;

    task automatic cmp(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t got %h want %h", n, $time, a, e);
        end
    endtask

    always @(negedge clock) begin
        if (chk) begin
            cmp("stall", 32'(stall), 32'(e_stall));
            cmp("bus_valid", 32'(bus_valid), 32'(e_valid));
            cmp("access_fault", 32'(access_fault), 32'(e_fault));
            if (e_valid) begin
                cmp("bus_address", bus_address, e_addr);
                cmp("bus_write", 32'(bus_write), 32'(e_write));
                cmp("bus_write_data", bus_write_data, e_wdata);
                cmp("bus_byte_enable", 32'(bus_byte_enable), 32'(e_be));
            end
            if (e_rd_chk)
                cmp("core_read_data", core_read_data, e_rdata);
            if (e_rst) begin
                cmp("rst_bus_address", bus_address, 32'h0);
                cmp("rst_bus_wdata", bus_write_data, 32'h0);
                cmp("rst_bus_be", 32'(bus_byte_enable), 32'h0);
                cmp("rst_bus_write", 32'(bus_write), 32'h0);
                cmp("rst_read_data", core_read_data, 32'h0);
            end
        end
    end

    // Model: access size, legality, lanes and extension from funct3.
    function automatic int unsigned msize(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit mlegal(input bit wr, input logic [2:0] f,
                                  input logic [31:0] a);
        int unsigned fi;
        fi = int'(f);
        if (wr && fi > 2) return 0;
        if (!wr && (fi == 3 || fi > 5)) return 0;
        return (int'(a[1:0]) % msize(f)) == 0;
    endfunction

    function automatic logic [3:0] mbe(input logic [2:0] f,
                                       input logic [31:0] a);
        int unsigned m;
        m = ((1 << msize(f)) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] mwdata(input logic [2:0] f,
                                           input logic [31:0] wd);
        logic [31:0] o;
        int unsigned s;
        s = msize(f);
        for (int i = 0; i < 4; i++)
            o[8*i +: 8] = wd[8*(i % s) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] mload(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] w);
        int unsigned v;
        v = w >> (8 * int'(a[1:0]));
        if (msize(f) == 1) begin
            v = v & 32'hFF;
            if (!f[2] && v >= 128) v = v + 32'hFFFFFF00;
        end else if (msize(f) == 2) begin
            v = v & 32'hFFFF;
            if (!f[2] && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_bus_exp(input bit wr, input logic [31:0] a,
                               input logic [2:0] f,
                               input logic [31:0] wd);
        e_addr  = {a[31:2], 2'b00};
        e_write = wr;
        e_wdata = mwdata(f, wd);
        e_be    = wr ? mbe(f, a) : 4'b0000;
    endtask

    // rsp < 0: no response ever (timeout path).
    task automatic xact(input bit wr, input logic [31:0] a,
                        input logic [2:0] f, input logic [31:0] wd,
                        input int rdly, input int rsp,
                        input logic [31:0] rword, input bit use_lit,
                        input logic [31:0] lit);
        bit ok;
        bit flt;
        ok = mlegal(wr, f, a);
        flt = 1'b0;
        core_address      = a;
        core_write_data   = wd;
        core_format       = f;
        core_read_enable  = !wr;
        core_write_enable = wr;
        bus_ready = 1'b0;
        bus_response_valid = 1'b0;
        e_stall = 1'b1; e_valid = 1'b0; e_fault = 1'b0;
        e_rd_chk = 1'b0;
        set_bus_exp(wr, a, f, wd);
        if (wr && use_lit) e_wdata = lit;
        e_rdata = (!wr && use_lit) ? lit : mload(f, a, rword);
        tick();
        if (!ok) begin
            flt = 1'b1;
            e_rdata = 32'h0;
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                bus_ready = (i == rdly);
                e_valid = 1'b1;
                tick();
            end
            bus_ready = 1'b0;
            e_valid = 1'b0;
            if (!wr) begin
                if (rsp < 0) begin
                    for (int i = 0; i < T; i++) tick();
                    flt = 1'b1;
                    e_rdata = 32'h0;
                end else begin
                    for (int i = 0; i <= rsp; i++) begin
                        bus_response_valid = (i == rsp);
                        bus_read_data = (i == rsp) ? rword
                                        : 32'h5A5A5A5A;
                        tick();
                    end
                    bus_response_valid = 1'b0;
                    bus_read_data = 32'h5A5A5A5A;
                end
            end
        end
        e_stall = 1'b0;
        e_fault = flt;
        e_rd_chk = !wr || flt;
        tick();
        e_fault = 1'b0;
        e_rd_chk = 1'b0;
    endtask

    task automatic idle(input int n);
        core_read_enable = 1'b0;
        core_write_enable = 1'b0;
        e_stall = 1'b0; e_valid = 1'b0; e_fault = 1'b0;
        e_rd_chk = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [2:0] lf [5];
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2;
        lf[3] = 3'd4; lf[4] = 3'd5;
        reset = 1'b0;
        core_address = '0; core_write_data = '0;
        core_read_enable = 1'b0; core_write_enable = 1'b0;
        core_format = '0; bus_ready = 1'b0;
        bus_response_valid = 1'b0; bus_read_data = 32'h5A5A5A5A;
        e_stall = 1'b0; e_valid = 1'b0; e_fault = 1'b0;
        e_write = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
        e_rdata = '0;
        tick();
        tick();
        chk = 1'b1;
        e_rst = 1'b1;
        tick();
        e_rst = 1'b0;
        reset = 1'b1;
        idle(1);

        // LW, then LB/LBU/LH with hand-computed results.
        xact(0, 32'h100, 3'd2, 0, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        xact(0, 32'h203, 3'd0, 0, 0, 0, 32'h80FF1234, 1, 32'hFFFFFF80);
        xact(0, 32'h203, 3'd4, 0, 0, 0, 32'h80FF1234, 1, 32'h00000080);
        xact(0, 32'h202, 3'd1, 0, 0, 0, 32'h80FF1234, 1, 32'hFFFF80FF);
        idle(1);

        // SB with two cycles of back-pressure.
        xact(1, 32'h301, 3'd0, 32'hAB, 2, 0, 0, 1, 32'hABABABAB);
        xact(1, 32'h302, 3'd1, 32'h1234BEEF, 0, 0, 0, 1, 32'hBEEFBEEF);
        xact(1, 32'h300, 3'd2, 32'hCAFEF00D, 1, 0, 0, 1, 32'hCAFEF00D);
        idle(2);

        // Rejected accesses.
        xact(1, 32'h402, 3'd2, 32'h11223344, 0, 0, 0, 0, 0);
        xact(0, 32'h401, 3'd1, 0, 0, 0, 32'h1, 0, 0);
        xact(0, 32'h400, 3'd3, 0, 0, 0, 32'h1, 0, 0);
        xact(0, 32'h400, 3'd6, 0, 0, 0, 32'h1, 0, 0);
        xact(1, 32'h400, 3'd4, 32'h55, 0, 0, 0, 0, 0);
        idle(1);

        // Sweep formats and offsets against the model.
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 5; k++)
                xact(0, 32'h700 + o, lf[k], 0, o % 2, 1,
                     32'h7F80C37E ^ (o * 32'h01010101), 0, 0);
            for (int f = 0; f < 3; f++)
                xact(1, 32'h800 + o, 3'(f), 32'h9A5B3C7D + o,
                     (f + o) % 2, 0, 0, 0, 0);
        end
        idle(1);

        // Timeout, then a stale response in IDLE, then a normal LW.
        xact(0, 32'h600, 3'd2, 0, 0, -1, 0, 0, 0);
        core_read_enable = 1'b0;
        bus_response_valid = 1'b1;
        bus_read_data = 32'h0BADF00D;
        idle(1);
        bus_response_valid = 1'b0;
        xact(0, 32'h604, 3'd2, 0, 0, 2, 32'h13579BDF, 1, 32'h13579BDF);
        idle(1);

        // Reset while waiting for a read response.
        core_address = 32'h500; core_format = 3'd2;
        core_read_enable = 1'b1; core_write_enable = 1'b0;
        e_stall = 1'b1; e_valid = 1'b0; e_fault = 1'b0;
        set_bus_exp(0, 32'h500, 3'd2, 0);
        tick();
        bus_ready = 1'b1; e_valid = 1'b1;
        tick();
        bus_ready = 1'b0; e_valid = 1'b0;
        tick();
        reset = 1'b0;
        core_read_enable = 1'b0;
        tick();
        reset = 1'b1;
        e_stall = 1'b0;
        bus_response_valid = 1'b1;
        bus_read_data = 32'hFFFFFFFF;
        tick();
        bus_response_valid = 1'b0;
        xact(0, 32'h504, 3'd2, 0, 0, 0, 32'h2468ACE0, 1, 32'h2468ACE0);
        idle(2);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
